// File: rtl/pmbus_page_regs.sv
// Multi-rail PMBus command decoder and register file: PAGE-selected rails,
// latched STATUS_BYTE faults, VOUT_COMMAND (vid) registers and SMBALERT#.
module pmbus_page_regs #(
  parameter int unsigned NCH  = 4,
  parameter int unsigned NBUF = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             EN,
  input  logic             cmd_vld,
  input  logic [7:0]       cmd,
  input  logic             wr_vld,
  input  logic [7:0]       wr_data,
  input  logic             rd_req,
  input  logic             stop,
  output logic [7:0]       rd_data,
  output logic             rd_vld,
  input  logic [8*NCH-1:0] vout,
  input  logic [8*NCH-1:0] iout,
  input  logic [8*NCH-1:0] tmp,
  input  logic [8*NCH-1:0] vin,
  input  logic [5*NCH-1:0] flt,
  output logic [8*NCH-1:0] vid,
  output logic [7:0]       page,
  output logic             smbal_n
);

  typedef enum logic [1:0] {IDLE, XFER, COMMIT} state_t;

  localparam logic [3:0] NB = 4'(NBUF);

  state_t     state, state_nx;
  logic [7:0] cmd_r;
  logic [3:0] bidx, binc;
  logic       wrote, ovf;
  logic [7:0] wbuf [NBUF];

  // Rail arrays are sized for the maximum of 8 rails so a 3-bit page index
  // addresses them directly; entries at or above NCH stay at zero.
  logic [7:0] vid_r  [8];
  logic [7:0] vhi_r  [8];
  logic [5:1] lat    [8];
  logic [4:0] fl     [8];
  logic [7:0] vout_a [8];
  logic [7:0] iout_a [8];
  logic [7:0] tmp_a  [8];
  logic [7:0] vin_a  [8];
  logic [7:0] stat   [8];

  logic [2:0] rsel;
  logic [7:0] tgt;
  logic [7:0] wb0, wb1, b0, b1, rbyte;
  logic [3:0] rlen, wlen;
  logic       wable, any_lat;
  logic       rd_fire, wr_fire, wr_drop, restart;
  logic       cml_evt, clr_evt, page_we, vout_we;

  always_comb begin
    for (int unsigned k = 0; k < 8; k++) begin
      fl[k]     = '0;
      vout_a[k] = '0;
      iout_a[k] = '0;
      tmp_a[k]  = '0;
      vin_a[k]  = '0;
      stat[k]   = '0;
    end
    vid     = '0;
    any_lat = 1'b0;
    for (int unsigned k = 0; k < NCH; k++) begin
      fl[k]     = flt[5*k +: 5];
      vout_a[k] = vout[8*k +: 8];
      iout_a[k] = iout[8*k +: 8];
      tmp_a[k]  = tmp[8*k +: 8];
      vin_a[k]  = vin[8*k +: 8];
      stat[k]   = {1'b0, fl[k][0], lat[k], fl[k][0] | (|lat[k])};
      vid[8*k +: 8] = vid_r[k];
      any_lat   = any_lat | (|lat[k]);
    end
  end

  // Broadcast page reads from rail 0 and targets every rail for updates.
  always_comb begin
    rsel = (page == 8'hFF) ? 3'd0 : page[2:0];
    tgt  = '0;
    for (int unsigned k = 0; k < NCH; k++)
      tgt[k] = (page == 8'hFF) || (rsel == 3'(k));
  end

  always_comb begin
    wb0 = '0;
    wb1 = '0;
    for (int unsigned i = 0; i < NBUF; i++) begin
      if (i == 0) wb0 = wbuf[i];
      if (i == 1) wb1 = wbuf[i];
    end
  end

  always_comb begin
    rlen  = '0;
    wlen  = '0;
    wable = 1'b0;
    b0    = '0;
    b1    = '0;
    case (cmd_r)
      8'h00: begin rlen = 4'd1; wlen = 4'd1; wable = 1'b1; b0 = page; end
      8'h21: begin
        rlen = 4'd2; wlen = 4'd2; wable = 1'b1;
        b0 = vid_r[rsel]; b1 = vhi_r[rsel];
      end
      8'h78: begin rlen = 4'd1; b0 = stat[rsel]; end
      8'h79: begin rlen = 4'd2; b0 = stat[rsel]; end
      8'h88: begin rlen = 4'd2; b0 = vin_a[rsel]; end
      8'h8B: begin rlen = 4'd2; b0 = vout_a[rsel]; end
      8'h8C: begin rlen = 4'd2; b0 = iout_a[rsel]; end
      8'h8D: begin rlen = 4'd2; b0 = tmp_a[rsel]; end
      default: ;
    endcase
    rbyte = 8'hFF;
    if (bidx < rlen) rbyte = (bidx == 4'd0) ? b0 : b1;
    binc = (bidx == 4'hF) ? bidx : bidx + 4'd1;
  end

  always_comb begin
    state_nx = state;
    restart  = 1'b0;
    rd_fire  = 1'b0;
    wr_fire  = 1'b0;
    wr_drop  = 1'b0;
    cml_evt  = 1'b0;
    clr_evt  = 1'b0;
    page_we  = 1'b0;
    vout_we  = 1'b0;
    case (state)
      IDLE: begin
        if (!stop && cmd_vld) begin
          state_nx = XFER;
          restart  = 1'b1;
        end
        if (rd_req || wr_vld) cml_evt = 1'b1;
      end
      XFER: begin
        if (stop)                  state_nx = COMMIT;
        else if (cmd_vld)          restart  = 1'b1;
        else if (rd_req && wr_vld) cml_evt  = 1'b1;
        else if (rd_req) begin
          rd_fire = 1'b1;
          if (bidx >= rlen) cml_evt = 1'b1;
        end else if (wr_vld) begin
          if (bidx >= NB) begin
            wr_drop = 1'b1;
            cml_evt = 1'b1;
          end else begin
            wr_fire = 1'b1;
          end
        end
      end
      COMMIT: begin
        state_nx = IDLE;
        if (rd_req || wr_vld) cml_evt = 1'b1;
        if (cmd_r == 8'h03) begin
          if (wrote) cml_evt = 1'b1;
          else       clr_evt = 1'b1;
        end else if (wrote) begin
          if (ovf || !wable || (bidx != wlen)) cml_evt = 1'b1;
          else if (cmd_r == 8'h00) begin
            if ((wb0 < 8'(NCH)) || (wb0 == 8'hFF)) page_we = 1'b1;
            else                                   cml_evt = 1'b1;
          end else begin
            vout_we = 1'b1;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cmd_r   <= '0;
      bidx    <= '0;
      wrote   <= 1'b0;
      ovf     <= 1'b0;
      page    <= '0;
      rd_data <= '0;
      rd_vld  <= 1'b0;
      smbal_n <= 1'b1;
      for (int unsigned i = 0; i < NBUF; i++) wbuf[i] <= '0;
      for (int unsigned k = 0; k < 8; k++) begin
        vid_r[k] <= '0;
        vhi_r[k] <= '0;
        lat[k]   <= '0;
      end
    end else if (EN) begin
      state   <= state_nx;
      rd_vld  <= rd_fire;
      smbal_n <= ~any_lat;
      if (restart) begin
        cmd_r <= cmd;
        bidx  <= '0;
        wrote <= 1'b0;
        ovf   <= 1'b0;
        for (int unsigned i = 0; i < NBUF; i++) wbuf[i] <= '0;
      end
      if (rd_fire) begin
        rd_data <= rbyte;
        bidx    <= binc;
      end
      if (wr_fire) begin
        for (int unsigned i = 0; i < NBUF; i++)
          if (bidx == 4'(i)) wbuf[i] <= wr_data;
        bidx  <= binc;
        wrote <= 1'b1;
      end
      if (wr_drop) begin
        wrote <= 1'b1;
        ovf   <= 1'b1;
      end
      if (page_we) page <= wb0;
      // Set terms are OR-ed after the clear so a fault present during
      // CLEAR_FAULTS stays latched.
      for (int unsigned k = 0; k < 8; k++) begin
        if (vout_we && tgt[k]) begin
          vid_r[k] <= wb0;
          vhi_r[k] <= wb1;
        end
        lat[k] <= (lat[k] & ~{5{clr_evt && tgt[k]}})
                | {fl[k][1], fl[k][2], fl[k][3], fl[k][4], cml_evt && tgt[k]};
      end
    end
  end

endmodule

// File: tb/tb_pmbus_page_regs.sv
// Directed bench for pmbus_page_regs (NCH=4): vector table plus hand-built
// sequences for fault latching, SMBALERT# timing and multi-byte reads.
module tb_pmbus_page_regs;

  logic        clk = 1'b0;
  logic        rst, EN, cmd_vld, wr_vld, rd_req, stop;
  logic [7:0]  cmd, wr_data, rd_data, page;
  logic        rd_vld, smbal_n;
  logic [31:0] vout, iout, tmp, vin, vid;
  logic [19:0] flt;

  int unsigned total = 0;
  int unsigned bad   = 0;

  pmbus_page_regs #(.NCH(4), .NBUF(2)) dut (
    .clk(clk), .rst(rst), .EN(EN), .cmd_vld(cmd_vld), .cmd(cmd),
    .wr_vld(wr_vld), .wr_data(wr_data), .rd_req(rd_req), .stop(stop),
    .rd_data(rd_data), .rd_vld(rd_vld), .vout(vout), .iout(iout),
    .tmp(tmp), .vin(vin), .flt(flt), .vid(vid), .page(page),
    .smbal_n(smbal_n)
  );

  always #5 clk = ~clk;

  typedef enum int unsigned {OP_CMD, OP_WR, OP_STOP, OP_RD, OP_NOP} op_e;
  typedef enum int unsigned {C_NONE, C_RD, C_PAGE, C_VID, C_SMB} chk_e;
  typedef struct {
    op_e         op;
    logic [7:0]  d;
    chk_e        chk;
    logic [31:0] exp;
  } vec_t;

  vec_t tv[$];

  function automatic void add(op_e o, logic [7:0] d, chk_e c, logic [31:0] e);
    vec_t v;
    v.op = o; v.d = d; v.chk = c; v.exp = e;
    tv.push_back(v);
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic do_cmd(input logic [7:0] c);
    cmd_vld = 1'b1; cmd = c; tick; cmd_vld = 1'b0;
  endtask

  task automatic do_wr(input logic [7:0] d);
    wr_vld = 1'b1; wr_data = d; tick; wr_vld = 1'b0;
  endtask

  // STOP edge then the COMMIT edge, so committed state is visible afterwards.
  task automatic do_stop;
    stop = 1'b1; tick; stop = 1'b0; tick;
  endtask

  task automatic do_rd(input string nm, input logic [7:0] e);
    rd_req = 1'b1; tick; rd_req = 1'b0;
    check(nm, {rd_vld, rd_data}, {1'b1, e});
  endtask

  task automatic read_status(input string nm, input logic [7:0] e);
    do_cmd(8'h78); do_rd(nm, e); do_stop;
  endtask

  initial begin
    rst = 1'b1; EN = 1'b1; cmd_vld = 1'b0; wr_vld = 1'b0; rd_req = 1'b0;
    stop = 1'b0; cmd = '0; wr_data = '0; flt = '0;
    vout = 32'h8877_6655; iout = 32'h1312_1110; tmp = 32'h2322_2120;
    vin  = 32'h4443_4241;

    tick; tick;
    rst = 1'b0;
    check("rst_page", page, 32'h0);
    check("rst_vid", vid, 32'h0);
    check("rst_smbal", smbal_n, 32'h1);
    check("rst_rdvld", rd_vld, 32'h0);

    add(OP_CMD, 8'h78, C_NONE, 0); add(OP_RD, 0, C_RD, 32'h00); add(OP_STOP, 0, C_NONE, 0);
    add(OP_CMD, 8'h00, C_NONE, 0); add(OP_WR, 8'h02, C_NONE, 0); add(OP_STOP, 0, C_PAGE, 32'h02);
    add(OP_CMD, 8'h21, C_NONE, 0); add(OP_WR, 8'h5A, C_NONE, 0); add(OP_WR, 8'h01, C_NONE, 0);
    add(OP_STOP, 0, C_VID, 32'h005A_0000);
    add(OP_CMD, 8'h21, C_NONE, 0); add(OP_RD, 0, C_RD, 32'h5A); add(OP_RD, 0, C_RD, 32'h01);
    add(OP_STOP, 0, C_SMB, 32'h1);
    add(OP_CMD, 8'h00, C_NONE, 0); add(OP_WR, 8'h01, C_NONE, 0); add(OP_CMD, 8'h00, C_NONE, 0);
    add(OP_STOP, 0, C_PAGE, 32'h02);
    add(OP_CMD, 8'h00, C_NONE, 0); add(OP_RD, 0, C_RD, 32'h02); add(OP_STOP, 0, C_NONE, 0);
    add(OP_CMD, 8'h00, C_NONE, 0); add(OP_WR, 8'hFF, C_NONE, 0); add(OP_STOP, 0, C_PAGE, 32'hFF);
    add(OP_CMD, 8'h21, C_NONE, 0); add(OP_WR, 8'h33, C_NONE, 0); add(OP_WR, 8'h00, C_NONE, 0);
    add(OP_STOP, 0, C_VID, 32'h3333_3333);
    add(OP_CMD, 8'h00, C_NONE, 0); add(OP_WR, 8'h07, C_NONE, 0); add(OP_STOP, 0, C_PAGE, 32'hFF);
    add(OP_NOP, 0, C_SMB, 32'h0);
    add(OP_CMD, 8'h78, C_NONE, 0); add(OP_RD, 0, C_RD, 32'h03); add(OP_STOP, 0, C_NONE, 0);
    add(OP_CMD, 8'h00, C_NONE, 0); add(OP_WR, 8'h03, C_NONE, 0); add(OP_STOP, 0, C_PAGE, 32'h03);
    add(OP_CMD, 8'h78, C_NONE, 0); add(OP_RD, 0, C_RD, 32'h03); add(OP_STOP, 0, C_NONE, 0);
    add(OP_CMD, 8'h00, C_NONE, 0); add(OP_WR, 8'hFF, C_NONE, 0); add(OP_STOP, 0, C_NONE, 0);
    add(OP_CMD, 8'h03, C_NONE, 0); add(OP_STOP, 0, C_NONE, 0);
    add(OP_CMD, 8'h78, C_NONE, 0); add(OP_RD, 0, C_RD, 32'h00); add(OP_STOP, 0, C_SMB, 32'h1);
    add(OP_CMD, 8'h88, C_NONE, 0); add(OP_RD, 0, C_RD, 32'h41); add(OP_RD, 0, C_RD, 32'h00);
    add(OP_STOP, 0, C_NONE, 0);

    for (int i = 0; i < tv.size(); i++) begin
      case (tv[i].op)
        OP_CMD:  do_cmd(tv[i].d);
        OP_WR:   do_wr(tv[i].d);
        OP_STOP: do_stop;
        OP_RD:   begin rd_req = 1'b1; tick; rd_req = 1'b0; end
        default: tick;
      endcase
      case (tv[i].chk)
        C_RD:   check($sformatf("vec%0d_rd", i), {rd_vld, rd_data}, {1'b1, tv[i].exp[7:0]});
        C_PAGE: check($sformatf("vec%0d_page", i), page, tv[i].exp);
        C_VID:  check($sformatf("vec%0d_vid", i), vid, tv[i].exp);
        C_SMB:  check($sformatf("vec%0d_smbal", i), smbal_n, tv[i].exp);
        default: ;
      endcase
    end

    // One-cycle VOUT_OV pulse on rail 1, then CLEAR_FAULTS timing.
    do_cmd(8'h00); do_wr(8'h01); do_stop;
    flt = 20'h00040; tick; flt = '0;
    check("ov_smbal_lag", smbal_n, 32'h1);
    tick;
    check("ov_smbal_low", smbal_n, 32'h0);
    read_status("ov_status", 8'h21);
    do_cmd(8'h03);
    stop = 1'b1; tick; stop = 1'b0; tick;
    check("clr_smbal_lag", smbal_n, 32'h0);
    tick;
    check("clr_smbal_high", smbal_n, 32'h1);
    read_status("clr_status", 8'h00);

    // Fault held through CLEAR_FAULTS stays latched.
    flt = 20'h00040;
    do_cmd(8'h03); do_stop;
    read_status("held_status", 8'h21);
    flt = '0;
    do_cmd(8'h03); do_stop; tick;
    check("held_release_smbal", smbal_n, 32'h1);

    // Short VOUT_COMMAND write: nothing committed, CML raised.
    do_cmd(8'h21); do_wr(8'h10); do_stop;
    check("short_vid", vid, 32'h3333_3333);
    read_status("short_status", 8'h03);
    check("short_smbal", smbal_n, 32'h0);
    do_cmd(8'h03); do_stop; tick;

    // Repeated start then three reads of a two-byte command.
    do_cmd(8'h8B); do_cmd(8'h8B);
    do_rd("rs_rd0", 8'h66); tick; check("rs_vld0_low", rd_vld, 32'h0);
    do_rd("rs_rd1", 8'h00); tick; check("rs_vld1_low", rd_vld, 32'h0);
    check("rs_smbal_pre", smbal_n, 32'h1);
    do_rd("rs_rd2", 8'hFF); tick; check("rs_vld2_low", rd_vld, 32'h0);
    check("rs_smbal_post", smbal_n, 32'h0);
    do_stop;
    read_status("rs_status", 8'h03);
    do_cmd(8'h03); do_stop; tick;

    // Disabled block ignores a full PAGE transaction.
    EN = 1'b0;
    do_cmd(8'h00); do_wr(8'h02); do_stop;
    EN = 1'b1;
    check("en_page", page, 32'h01);

    // Reset in the middle of a transaction commits nothing.
    do_cmd(8'h00); do_wr(8'h02);
    rst = 1'b1; tick; rst = 1'b0;
    do_stop;
    check("midrst_page", page, 32'h00);
    check("midrst_vid", vid, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
